reaction_ctrl: RTL

Trial sequencer for the reaction-time tester. On `start` it draws one value from the RanGen random source, waits a random delay in milliseconds, lights the GO LED, then measures in milliseconds how long the player takes to respond. It flags false starts and timeouts, and holds the result for the display path until the next trial. It sits between the debounced button inputs, the RanGen instance and the display/score logic.

---
 rtl/reaction_pkg.sv | 18 +
 rtl/reaction_ctrl_ms_tick.sv | 26 ++
 rtl/reaction_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and widths for the reaction-time trial sequencer.
package reaction_pkg;

    localparam int RAND_W = 16;
    localparam int RES_W  = 14;
    localparam int DLY_W  = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        GO    = 3'd4,
        DONE  = 3'd5,
        FAULT = 3'd6
    } state_t;

endpackage

// File: rtl/reaction_ctrl_ms_tick.sv
// Millisecond prescaler: free-running 0..CLK_PER_MS-1 counter, tick on the last count.
module ms_tick #(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: random pre-GO delay, then ms-resolution response timing.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned       CLK_PER_MS   = 100000,
    parameter int unsigned       MIN_DELAY_MS = 1000,
    parameter logic [RAND_W-1:0] RAND_MASK    = 16'h07FF,
    parameter int unsigned       MAX_TIME_MS  = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp,
    input  logic [RAND_W-1:0] rand_in,
    output logic              rand_next,
    output logic              led_go,
    output logic              busy,
    output logic [RES_W-1:0]  result_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              timeout
);
    localparam logic [RES_W-1:0] MAX_MS = RES_W'(MAX_TIME_MS);

    state_t           state, state_d;
    logic [DLY_W-1:0] dly;
    logic [RES_W-1:0] ms_cnt;
    logic             tick, pre_clr, last_tick, max_tick;

    // Prescaler only runs while timing; holding it clear elsewhere covers the LOAD clear.
    assign pre_clr = !(state == WAIT || state == GO);

    ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign last_tick = (state == WAIT) && tick && (dly <= DLY_W'(1));
    assign max_tick  = (state == GO) && tick && (ms_cnt >= MAX_MS - 1'b1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:        if (start) state_d = ARM;
            ARM:         state_d = resp ? FAULT : LOAD;
            LOAD:        state_d = resp ? FAULT : WAIT;
            WAIT: begin
                if (resp)           state_d = FAULT;
                else if (last_tick) state_d = GO;
            end
            GO:          if (resp || max_tick) state_d = DONE;
            DONE, FAULT: if (start) state_d = ARM;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs are registered off the next state so nothing combinational reaches a pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rand_next    <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            dly          <= '0;
            ms_cnt       <= '0;
        end else begin
            rand_next <= (state_d == ARM);
            led_go    <= (state_d == GO);
            busy      <= (state_d inside {ARM, LOAD, WAIT, GO});

            if (state == LOAD)
                dly <= DLY_W'(MIN_DELAY_MS) + DLY_W'(rand_in & RAND_MASK);
            else if (state == WAIT && tick && dly != '0)
                dly <= dly - 1'b1;

            if (state_d == GO && state != GO)
                ms_cnt <= '0;
            else if (state == GO && tick && ms_cnt < MAX_MS)
                ms_cnt <= ms_cnt + 1'b1;

            if (state_d == ARM) begin
                result_ms    <= '0;
                result_valid <= 1'b0;
                false_start  <= 1'b0;
                timeout      <= 1'b0;
            end else if (state == GO && state_d == DONE) begin
                result_valid <= 1'b1;
                if (resp) begin
                    result_ms <= ms_cnt;
                end else begin
                    result_ms <= MAX_MS;
                    timeout   <= 1'b1;
                end
            end else if (state_d == FAULT && state != FAULT) begin
                false_start  <= 1'b1;
                result_valid <= 1'b0;
                result_ms    <= '0;
            end
        end
    end

endmodule
